// File: rtl/pwm_bank.sv
// Multi-channel PWM peripheral: one shared period counter (edge or center aligned),
// shadowed period/duty registers, per-channel compare outputs and a sticky wrap interrupt.
module pwm_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [5:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] pwmOut,
  output logic              periodIrq
);

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic              en, mode, irqen;
  logic [NUM_CH-1:0] chen;
  logic [CNT_W-1:0]  period_sh, period_act;
  logic [CNT_W-1:0]  duty_sh  [NUM_CH];
  logic [CNT_W-1:0]  duty_act [NUM_CH];
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              dir, dir_nxt;
  logic              wrap;

  logic [3:0]        word;
  logic              wr, rd, wr_ctrl, wr_period, wr_status;
  logic [NUM_CH-1:0] wr_duty;
  logic              en_next, enable_edge, run, update, load_act;
  logic [31:0]       rd_val;
  logic              unused_bits;

  assign word        = addr[5:2];
  assign wr          = sel & we;
  assign rd          = sel & ~we;
  assign wr_ctrl     = wr && (word == 4'd0);
  assign wr_period   = wr && (word == 4'd1);
  assign wr_status   = wr && (word == 4'd2);
  assign unused_bits = ^{addr[1:0], wdata};

  // A disabling CTRL write must already zero cnt/pwmOut at its own edge, so
  // "running" needs EN both now and in the next cycle.
  assign en_next     = wr_ctrl ? wdata[0] : en;
  assign enable_edge = ~en & en_next;
  assign run         = en & en_next;
  assign update      = en && (cnt_nxt == '0);
  assign load_act    = update | enable_edge;
  assign periodIrq   = wrap & irqen;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wr_duty = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_duty[i] = wr && (word == 4'(4 + i));
    end
  end

  always_comb begin
    cnt_nxt = '0;
    dir_nxt = DIR_UP;
    if (period_act != '0) begin
      if (!mode) begin
        cnt_nxt = (cnt >= period_act) ? '0 : cnt + ONE;
      end else if (dir == DIR_UP) begin
        if (cnt >= period_act) begin
          cnt_nxt = period_act - ONE;
          dir_nxt = (period_act == ONE) ? DIR_UP : DIR_DOWN;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end else if (cnt > ONE) begin
        cnt_nxt = cnt - ONE;
        dir_nxt = DIR_DOWN;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (word)
      4'd0: begin
        rd_val[0]           = en;
        rd_val[1]           = mode;
        rd_val[2]           = irqen;
        rd_val[8 +: NUM_CH] = chen;
      end
      4'd1: rd_val[CNT_W-1:0] = period_sh;
      4'd2: rd_val[0] = wrap;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (word == 4'(4 + i)) rd_val[CNT_W-1:0] = duty_sh[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the duty arrays are real registers with architected reset values,
      // so they are cleared element by element rather than left as memory.
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
      en         <= 1'b0;
      mode       <= 1'b0;
      irqen      <= 1'b0;
      chen       <= '0;
      period_sh  <= '0;
      period_act <= '0;
      cnt        <= '0;
      dir        <= DIR_UP;
      wrap       <= 1'b0;
      pwmOut     <= '0;
      rdata      <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every right-hand side sees
      // pre-edge values; a same-cycle shadow write therefore misses this load.
      if (wr_ctrl) begin
        en    <= wdata[0];
        mode  <= wdata[1];
        irqen <= wdata[2];
        chen  <= wdata[8 +: NUM_CH];
      end
      if (wr_period) period_sh <= wdata[CNT_W-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_duty[i]) duty_sh[i] <= wdata[CNT_W-1:0];
        if (load_act)   duty_act[i] <= duty_sh[i];
        pwmOut[i] <= run & chen[i] & (cnt < duty_act[i]);
      end
      if (load_act) period_act <= period_sh;

      cnt <= run ? cnt_nxt : '0;
      dir <= run ? dir_nxt : DIR_UP;

      if (update)                      wrap <= 1'b1;
      else if (wr_status && wdata[0])  wrap <= 1'b0;

      if (rd) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: directed scenarios plus random bus traffic,
// compared every cycle against a phase-based behavioural model.
module tb_pwm_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sel = 1'b0;
  logic              we = 1'b0;
  logic [5:0]        addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] pwmOut;
  logic              periodIrq;

  int n_checks = 0;
  int n_fails  = 0;
  bit checking = 1'b0;

  pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .pwmOut(pwmOut), .periodIrq(periodIrq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: the counter is described by its phase k within one period.
  bit          m_en, m_mode, m_irqen, m_wrap;
  bit [7:0]    m_chen;
  longint      m_per_sh, m_per_act, m_k;
  longint      m_duty_sh [NUM_CH];
  longint      m_duty_act[NUM_CH];
  bit [NUM_CH-1:0] m_pwm;
  logic [31:0] m_rdata;

  function automatic longint cnt_of(longint k, longint p, bit md);
    if (!md) return k;
    return (k <= p) ? k : 2 * p - k;
  endfunction

  function automatic longint period_len(longint p, bit md);
    if (p == 0) return 1;
    return md ? 2 * p : p + 1;
  endfunction

  function automatic logic [31:0] model_read(int w);
    logic [31:0] v = '0;
    if (w == 0) v = {16'd0, m_chen, 5'd0, m_irqen, m_mode, m_en};
    else if (w == 1) v = 32'(m_per_sh);
    else if (w == 2) v = {31'd0, m_wrap};
    else if (w >= 4 && w < 4 + NUM_CH) v = 32'(m_duty_sh[w-4]);
    return v;
  endfunction

  bit     s_wr, s_rd, s_new_en, s_upd;
  int     s_word;
  longint s_len, s_cur;

  always @(posedge clk) begin
    if (rst) begin
      m_en = 0; m_mode = 0; m_irqen = 0; m_wrap = 0; m_chen = '0;
      m_per_sh = 0; m_per_act = 0; m_k = 0; m_pwm = '0; m_rdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_duty_sh[i] = 0;
        m_duty_act[i] = 0;
      end
    end else begin
      s_wr     = sel && we;
      s_rd     = sel && !we;
      s_word   = int'(addr[5:2]);
      s_len    = period_len(m_per_act, m_mode);
      s_cur    = cnt_of(m_k, m_per_act, m_mode);
      s_new_en = (s_wr && s_word == 0) ? wdata[0] : m_en;
      s_upd    = m_en && ((m_k + 1) % s_len == 0);
      for (int i = 0; i < NUM_CH; i++)
        m_pwm[i] = m_en && s_new_en && m_chen[i] && (s_cur < m_duty_act[i]);
      m_k = (m_en && s_new_en) ? (m_k + 1) % s_len : 0;
      if (s_rd) m_rdata = model_read(s_word);
      if (s_upd || (!m_en && s_new_en)) begin
        m_per_act = m_per_sh;
        for (int i = 0; i < NUM_CH; i++) m_duty_act[i] = m_duty_sh[i];
      end
      if (s_upd) m_wrap = 1;
      else if (s_wr && s_word == 2 && wdata[0]) m_wrap = 0;
      if (s_wr) begin
        if (s_word == 0) begin
          m_en = wdata[0]; m_mode = wdata[1]; m_irqen = wdata[2];
          m_chen = 8'(wdata[8 +: NUM_CH]);
        end else if (s_word == 1) begin
          m_per_sh = longint'(wdata[CNT_W-1:0]);
        end else if (s_word >= 4 && s_word < 4 + NUM_CH) begin
          m_duty_sh[s_word-4] = longint'(wdata[CNT_W-1:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("pwm", 32'(pwmOut), 32'(m_pwm));
      check("irq", 32'(periodIrq), 32'(m_wrap & m_irqen));
      check("rdata", rdata, m_rdata);
    end
  end

  task automatic bus_write(input int w, input logic [31:0] d);
    sel = 1; we = 1; addr = 6'(w * 4); wdata = d;
    @(negedge clk);
    sel = 0; we = 0;
  endtask

  task automatic bus_read(input int w);
    sel = 1; we = 0; addr = 6'(w * 4);
    @(negedge clk);
    sel = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int          r, w;
  bit          ne, md;
  logic [31:0] d;

  initial begin
    idle(3);
    checking = 1;
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      bus_read(i == 3 ? 4 : i);
      check("reset_read", rdata, 32'd0);
    end
    check("reset_pwm", 32'(pwmOut), 32'd0);

    // Edge mode 3 high / 7 low, then a shadowed duty change mid-period.
    bus_write(1, 9);
    bus_write(4, 3);
    bus_write(0, 32'h101);
    idle(25);
    bus_write(4, 7);
    idle(30);

    // Center mode, period 4, duty1 2.
    bus_write(0, 0);
    bus_write(1, 4);
    bus_write(5, 2);
    bus_write(0, 32'h203);
    idle(20);

    // Duty 0 and duty P+1 on two channels.
    bus_write(0, 0);
    bus_write(4, 0);
    bus_write(5, 5);
    bus_write(0, 32'h301);
    idle(15);

    // Period 0: constant output, wrap every cycle.
    bus_write(0, 0);
    bus_write(1, 0);
    bus_write(4, 1);
    bus_write(0, 32'h101);
    idle(6);
    bus_read(2);
    check("p0_wrap", rdata, 32'd1);
    check("p0_pwm", 32'(pwmOut[0]), 32'd1);

    // Interrupt with period 3; first W1C lands on an update event.
    bus_write(0, 0);
    bus_write(2, 1);
    bus_write(1, 3);
    bus_write(0, 32'h105);
    idle(3);
    bus_write(2, 1);
    bus_read(2);
    check("w1c_vs_update", rdata, 32'd1);
    bus_write(2, 1);
    check("irq_cleared", 32'(periodIrq), 32'd0);
    bus_read(2);
    check("w1c_read", rdata, 32'd0);
    idle(4);

    // Disable mid-period, then reset mid-period.
    bus_write(0, 0);
    bus_write(1, 9);
    bus_write(4, 5);
    bus_write(0, 32'h101);
    idle(4);
    bus_write(0, 0);
    check("disable_pwm", 32'(pwmOut), 32'd0);
    bus_read(1);
    check("period_kept", rdata, 32'd9);
    bus_write(0, 32'h107);
    idle(7);
    rst = 1;
    idle(1);
    rst = 0;
    check("rst_pwm", 32'(pwmOut), 32'd0);
    check("rst_irq", 32'(periodIrq), 32'd0);
    bus_read(1);
    check("rst_period", rdata, 32'd0);

    // Random bus traffic.
    for (int it = 0; it < 500; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: idle($urandom_range(1, 8));
        4: bus_write(1, $urandom_range(0, 12));
        5: bus_write(4 + $urandom_range(0, NUM_CH - 1), $urandom_range(0, 14));
        6: begin
          ne = ($urandom_range(0, 3) != 0);
          md = (m_en && ne) ? m_mode : 1'($urandom_range(0, 1));
          d  = {16'd0, 8'($urandom_range(0, 255)), 5'd0, 1'($urandom_range(0, 1)), md, ne};
          bus_write(0, d);
        end
        7: bus_write(2, $urandom);
        8: begin
          sel = 1; we = 0; addr = 6'($urandom_range(0, 63));
          @(negedge clk);
          sel = 0;
        end
        default: begin
          w = ($urandom_range(0, 1) != 0) ? 3 : $urandom_range(4 + NUM_CH, 15);
          bus_write(w, $urandom);
        end
      endcase
    end
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
